// File: rtl/edm_pulse_generator.sv
// EDM discharge pulse timing: ignition, gap-breakdown detection, timed discharge and off period.
// Every output is registered from next-state values so it changes on the edge of the transition it belongs to.
module edm_pulse_generator #(
    parameter int          TICK_DIV     = 100,
    parameter logic [15:0] BRK_THRESH   = 16'd1200,
    parameter logic [15:0] SHORT_THRESH = 16'd300,
    parameter int          BRK_CONFIRM  = 4,
    parameter logic [15:0] OPEN_TIMEOUT = 16'd200,
    parameter logic [15:0] RAMP_STEP    = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_machine,
    input  logic [15:0] Ton_data,
    input  logic [15:0] Toff_data,
    input  logic [15:0] Ip_data,
    input  logic [15:0] waveform_data,
    input  logic [15:0] sample_voltage,
    output logic [7:0]  PWM,
    output logic [1:0]  PWM_Q,
    output logic        pulse_start,
    output logic        pulse_done,
    output logic [1:0]  pulse_type
);

    typedef enum logic [1:0] {S_IDLE, S_IGNITE, S_DISCH, S_OFF} state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] CONFIRM_N = 16'(BRK_CONFIRM);

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] brk_cnt_q, brk_cnt_d;
    logic [15:0] ton_q, ton_d;
    logic [15:0] toff_q, toff_d;
    logic [3:0]  legs_q, legs_d;
    logic        ramp_q, ramp_d;
    logic [3:0]  ramp_legs_q, ramp_legs_d;
    logic [15:0] ramp_sub_q, ramp_sub_d;

    logic [7:0]  pwm_out_q, pwm_out_d;
    logic [1:0]  gate_q, gate_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic [1:0]  type_q, type_d;

    logic        tick, low, ip_ok, first_cyc, entry;
    logic [16:0] tick_cnt_inc;
    logic [15:0] brk_inc;
    logic        latch, short_hit, open_hit, brk_hit, dis_end;
    logic        unused_ok;

    function automatic logic [7:0] leg_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

    assign tick         = (presc_q == TICK_LAST);
    assign tick_cnt_inc = {1'b0, tick_cnt_q} + 17'd1;
    assign low          = (sample_voltage < BRK_THRESH);
    assign brk_inc      = low ? (brk_cnt_q + 16'd1) : 16'd0;
    assign ip_ok        = (Ip_data[3:0] != 4'd0);
    // Prescaler and tick count restart on every state entry, so both zero marks the first cycle.
    assign first_cyc    = (presc_q == 16'd0) && (tick_cnt_q == 16'd0);
    assign entry        = (state_d != state_q);
    assign unused_ok    = ^{Ip_data[15:4], waveform_data[15:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            tick_cnt_q  <= '0;
            brk_cnt_q   <= '0;
            ton_q       <= '0;
            toff_q      <= '0;
            legs_q      <= '0;
            ramp_q      <= 1'b0;
            ramp_legs_q <= '0;
            ramp_sub_q  <= '0;
            pwm_out_q   <= '0;
            gate_q      <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            type_q      <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_cnt_q  <= tick_cnt_d;
            brk_cnt_q   <= brk_cnt_d;
            ton_q       <= ton_d;
            toff_q      <= toff_d;
            legs_q      <= legs_d;
            ramp_q      <= ramp_d;
            ramp_legs_q <= ramp_legs_d;
            ramp_sub_q  <= ramp_sub_d;
            pwm_out_q   <= pwm_out_d;
            gate_q      <= gate_d;
            start_q     <= start_d;
            done_q      <= done_d;
            type_q      <= type_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latch     = 1'b0;
        short_hit = 1'b0;
        open_hit  = 1'b0;
        brk_hit   = 1'b0;
        dis_end   = 1'b0;
        if (!is_machine) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ip_ok) begin
                        latch   = 1'b1;
                        state_d = S_IGNITE;
                    end
                end
                S_IGNITE: begin
                    // Breakdown is tested before timeout so it wins a tie.
                    if (first_cyc && (sample_voltage < SHORT_THRESH)) begin
                        short_hit = 1'b1;
                        state_d   = S_OFF;
                    end else if (brk_inc == CONFIRM_N) begin
                        brk_hit = 1'b1;
                        state_d = S_DISCH;
                    end else if (tick && (tick_cnt_inc == {1'b0, OPEN_TIMEOUT})) begin
                        open_hit = 1'b1;
                        state_d  = S_OFF;
                    end
                end
                S_DISCH: begin
                    if (tick && (tick_cnt_inc == {1'b0, ton_q})) begin
                        dis_end = 1'b1;
                        state_d = S_OFF;
                    end
                end
                S_OFF: begin
                    if (tick && (tick_cnt_inc == {1'b0, toff_q})) begin
                        if (ip_ok) begin
                            latch   = 1'b1;
                            state_d = S_IGNITE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        presc_d     = presc_q;
        tick_cnt_d  = tick_cnt_q;
        brk_cnt_d   = 16'd0;
        ton_d       = ton_q;
        toff_d      = toff_q;
        legs_d      = legs_q;
        ramp_d      = ramp_q;
        ramp_legs_d = ramp_legs_q;
        ramp_sub_d  = ramp_sub_q;

        if (entry || (state_q == S_IDLE)) begin
            presc_d    = 16'd0;
            tick_cnt_d = 16'd0;
        end else if (tick) begin
            presc_d    = 16'd0;
            tick_cnt_d = tick_cnt_inc[15:0];
        end else begin
            presc_d = presc_q + 16'd1;
        end

        if (!entry && (state_q == S_IGNITE)) begin
            brk_cnt_d = brk_inc;
        end

        if (latch) begin
            ton_d  = (Ton_data == 16'd0) ? 16'd1 : Ton_data;
            toff_d = (Toff_data == 16'd0) ? 16'd1 : Toff_data;
            legs_d = Ip_data[3] ? 4'd8 : Ip_data[3:0];
            ramp_d = (waveform_data[1:0] == 2'd1);
        end

        if (entry && (state_d == S_DISCH)) begin
            ramp_legs_d = 4'd1;
            ramp_sub_d  = 16'd0;
        end else if ((state_q == S_DISCH) && tick) begin
            if (({1'b0, ramp_sub_q} + 17'd1) == {1'b0, RAMP_STEP}) begin
                ramp_sub_d  = 16'd0;
                ramp_legs_d = (ramp_legs_q < legs_q) ? (ramp_legs_q + 4'd1) : ramp_legs_q;
            end else begin
                ramp_sub_d = ramp_sub_q + 16'd1;
            end
        end
    end

    always_comb begin
        pwm_out_d = 8'd0;
        gate_d    = 2'b00;
        start_d   = brk_hit;
        done_d    = short_hit | open_hit | dis_end;
        type_d    = short_hit ? 2'd2 : (open_hit ? 2'd1 : 2'd0);
        case (state_d)
            S_IGNITE: gate_d = 2'b01;
            S_DISCH: begin
                gate_d    = 2'b10;
                pwm_out_d = leg_mask(ramp_q ? ramp_legs_d : legs_q);
            end
            default: gate_d = 2'b00;
        endcase
    end

    assign PWM         = pwm_out_q;
    assign PWM_Q       = gate_q;
    assign pulse_start = start_q;
    assign pulse_done  = done_q;
    assign pulse_type  = type_q;

endmodule

// File: doc/edm_pulse_generator.md
Name: edm_pulse_generator

Overview:
- Discharge pulse timing stage sitting directly downstream of parameter_generator; consumes is_machine, Ton_data, Toff_data, Ip_data and waveform_data (all already synchronous to clk) plus sample_voltage from ad_sample.
- Per pulse: drives the ignition switch, detects gap breakdown, times the discharge, then times the off period. Produces PWM[7:0]/PWM_Q[1:0] for the MOSFET drivers and per-pulse classification strobes for pulse_sort.

Parameters:
- TICK_DIV, 100, clk cycles per timing tick (1 us at 100 MHz).
- BRK_THRESH, 16'd1200, sample_voltage below this means gap broken down.
- SHORT_THRESH, 16'd300, sample_voltage below this on ignition entry means short circuit.
- BRK_CONFIRM, 4, consecutive clk samples below BRK_THRESH required to confirm breakdown.
- OPEN_TIMEOUT, 16'd200, ticks without breakdown before the pulse is declared open (null).
- RAMP_STEP, 16'd2, ticks between successive leg enables in ramp waveform.

Ports:
- clk  in  1  system clock (clk_100M domain).
- rst  in  1  synchronous reset, active-high.
- is_machine  in  1  machining enable level.
- Ton_data  in  16  discharge duration in ticks.
- Toff_data  in  16  off duration in ticks.
- Ip_data  in  16  current level; [3:0] = number of buck legs enabled, saturated at 8.
- waveform_data  in  16  [1:0]: 0 = rectangular, 1 = ramp, 2/3 treated as rectangular.
- sample_voltage  in  16  gap voltage sample.
- PWM  out  8  buck leg gates; legs fill from bit 0 upward.
- PWM_Q  out  2  [0] ignition/high-voltage switch, [1] main discharge gate.
- pulse_start  out  1  one-cycle strobe on entry to DISCHARGE.
- pulse_done  out  1  one-cycle strobe when a pulse is classified.
- pulse_type  out  2  valid with pulse_done: 0 normal, 1 open/null, 2 short.

Behaviour:
- Reset: state IDLE; all outputs 0; counters and latched parameters 0.
- All outputs are registered and change on the same edge as the state transition they belong to.
- Tick prescaler: counts 0..TICK_DIV-1 and restarts at 0 on every state entry. tick = prescaler at TICK_DIV-1.
- IDLE:
  - All outputs 0.
  - When is_machine=1 and Ip_data[3:0]!=0: latch Ton, Toff, legs = min(Ip_data[3:0], 8) and waveform, then go to IGNITE.
  - Ton=0 or Toff=0 are latched as 1.
- IGNITE:
  - PWM_Q = 2'b01, PWM = 0.
  - If sample_voltage < SHORT_THRESH on the first IGNITE cycle: pulse_done=1, pulse_type=2, go to OFF.
  - Otherwise count consecutive clk samples below BRK_THRESH; any sample >= BRK_THRESH resets the count.
  - Count reaching BRK_CONFIRM: go to DISCHARGE, pulse_start=1.
  - OPEN_TIMEOUT ticks elapsed first: pulse_done=1, pulse_type=1, go to OFF.
  - If confirm and timeout fall in the same cycle, breakdown wins.
- DISCHARGE:
  - PWM_Q = 2'b10.
  - Rectangular: PWM = (1<<legs)-1 for the whole phase.
  - Ramp: starts with 1 leg and adds one leg every RAMP_STEP ticks, capped at legs.
  - Lasts exactly Ton ticks, then pulse_done=1, pulse_type=0, go to OFF.
- OFF:
  - PWM = 0, PWM_Q = 0.
  - Lasts Toff ticks. Then, if is_machine=1 and Ip_data[3:0]!=0, re-latch parameters and go to IGNITE; otherwise go to IDLE.
- Parameter changes mid-pulse do not take effect until the next latch point.
- is_machine falling in any state: next edge goes to IDLE, all gates 0, no pulse_done for the aborted pulse.
- Reset asserted mid-pulse: gates 0 on that edge.
- Safety invariant: PWM_Q[0] and PWM_Q[1] are never 1 together; PWM != 0 only in DISCHARGE.
- Tick, timeout and Ton/Toff counters are 16-bit. The 0xFFFF maximum must not wrap early.

Test Plan:
- Normal pulse. Setup: TICK_DIV=4, Ton=3, Toff=2, Ip=3, waveform=0, is_machine=1; sample_voltage 3000, dropping to 1000 after 10 cycles of IGNITE. Expect: DISCHARGE entered 4 cycles after the drop; PWM=8'h07 for 12 cycles; pulse_type=0; OFF for 8 cycles; then IGNITE again.
- Open pulse. Setup: sample_voltage held at 3000, OPEN_TIMEOUT=5 (TICK_DIV=4). Expect: PWM_Q=01 for 20 cycles, then pulse_done with pulse_type=1, PWM never asserted.
- Short pulse. Setup: sample_voltage=100 on IGNITE entry. Expect: pulse_type=2 on the first IGNITE cycle, PWM=0 throughout.
- Ramp. Setup: Ip=4, waveform=1, RAMP_STEP=1, Ton=6. Expect PWM sequence 01, 03, 07, 0F, 0F, 0F, one value per tick.
- Glitch rejection. Setup: sample_voltage below BRK_THRESH for 3 cycles, then above, then below for 4. Expect breakdown only after the 4-cycle run.
- Abort and latching. Setup: drop is_machine mid-DISCHARGE. Expect all outputs 0 on the next edge, no pulse_done. Setup: change Ton mid-DISCHARGE. Expect the current pulse keeps the old Ton and the next pulse uses the new one.
